// File: rtl/bus_hub_pkg.sv
// rtl/bus_hub_pkg.sv - shared types and constants for the N-device pipelined bus hub
package bus_hub_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/bus_prio_sel.sv
// rtl/bus_prio_sel.sv - lowest-set-bit priority encoder (one-hot, index, any_set)
module bus_prio_sel #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] index,
    output logic             any_set
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        onehot  = '0;
        index   = '0;
        any_set = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                index     = IDX_W'(i);
                any_set   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_hub_n_pl.sv
// rtl/bus_hub_n_pl.sv - registered-request, priority-decoded N-device bus hub with error responses
// Optional timeout counter enabled by defining BUS_HUB_TIMEOUT_EN.
module bus_hub_n_pl
    import bus_hub_pkg::*;
#(
    parameter int N_DEVICES      = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_RDATA_DEFAULT),
    localparam int MASK_W = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           host_address,
    input  logic [DATA_W-1:0]           host_data_write,
    input  logic [MASK_W-1:0]           host_write_mask,
    input  logic                        host_wen,
    input  logic                        host_ren,
    output logic [DATA_W-1:0]           host_data_read,
    output logic                        host_ready,
    output logic                        host_error,
    output logic [N_DEVICES*ADDR_W-1:0] device_address,
    output logic [N_DEVICES*DATA_W-1:0] device_data_write,
    output logic [N_DEVICES*MASK_W-1:0] device_write_mask,
    output logic [N_DEVICES-1:0]        device_wen,
    output logic [N_DEVICES-1:0]        device_ren,
    input  logic [N_DEVICES-1:0]        device_ready,
    input  logic [N_DEVICES*DATA_W-1:0] device_data_read,
    input  logic [N_DEVICES-1:0]        device_active
);

    localparam int IDX_W = (N_DEVICES > 1) ? $clog2(N_DEVICES) : 1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    state_t              state, state_n;
    op_t                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   mask_q;
    logic [N_DEVICES-1:0] sel_oh_q;
    logic [IDX_W-1:0]    sel_idx_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic [N_DEVICES-1:0] hit_oh;
    logic [IDX_W-1:0]    hit_idx;
    logic                hit_any;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rdata;
    logic                timeout_hit;

    bus_prio_sel #(.N(N_DEVICES), .IDX_W(IDX_W)) u_prio (
        .req     (device_active),
        .onehot  (hit_oh),
        .index   (hit_idx),
        .any_set (hit_any)
    );

    // Only the latched device's ready/data are observed; other slices are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_DEVICES; i++) begin
            if (IDX_W'(i) == sel_idx_q) begin
                sel_ready = device_ready[i];
                sel_rdata = device_data_read[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BUS_HUB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state == DECODE) begin
            cnt_q <= '0;
        end else if (state == ACCESS && !sel_ready && !timeout_hit &&
                     cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        device_ren = '0;
        device_wen = '0;
        host_ready = 1'b0;
        host_error = 1'b0;
        case (state)
            IDLE:   if (host_ren || host_wen) state_n = DECODE;
            DECODE: state_n = hit_any ? ACCESS : RESP;
            ACCESS: begin
                if (op_q == OP_WRITE) device_wen = sel_oh_q;
                else                  device_ren = sel_oh_q;
                if (sel_ready || timeout_hit) state_n = RESP;
            end
            RESP: begin
                host_ready = 1'b1;
                host_error = err_q;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            sel_oh_q  <= '0;
            sel_idx_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_ren || host_wen) begin
                        op_q    <= host_wen ? OP_WRITE : OP_READ;
                        addr_q  <= host_address;
                        wdata_q <= host_data_write;
                        mask_q  <= host_write_mask;
                        err_q   <= 1'b0;
                    end
                end
                DECODE: begin
                    if (hit_any) begin
                        sel_oh_q  <= hit_oh;
                        sel_idx_q <= hit_idx;
                    end else begin
                        err_q   <= 1'b1;
                        rdata_q <= (op_q == OP_READ) ? ERR_RDATA : '0;
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        rdata_q <= (op_q == OP_READ) ? sel_rdata : '0;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= (op_q == OP_READ) ? ERR_RDATA : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign host_data_read    = rdata_q;
    assign device_address    = {N_DEVICES{addr_q}};
    assign device_data_write = {N_DEVICES{wdata_q}};
    assign device_write_mask = {N_DEVICES{mask_q}};

endmodule

// File: tb/tb_bus_hub_n_pl.sv
// tb/tb_bus_hub_n_pl.sv - self-checking bench for bus_hub_n_pl (directed and random transactions)
module tb_bus_hub_n_pl;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int T  = 8;
    localparam int NEVER = 1000000;
    localparam logic [DW-1:0] ERRV = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0]   host_address = '0;
    logic [DW-1:0]   host_data_write = '0;
    logic [MW-1:0]   host_write_mask = '0;
    logic            host_wen = 1'b0;
    logic            host_ren = 1'b0;
    logic [DW-1:0]   host_data_read;
    logic            host_ready;
    logic            host_error;
    logic [N*AW-1:0] device_address;
    logic [N*DW-1:0] device_data_write;
    logic [N*MW-1:0] device_write_mask;
    logic [N-1:0]    device_wen;
    logic [N-1:0]    device_ren;
    logic [N-1:0]    device_ready;
    logic [N*DW-1:0] device_data_read;
    logic [N-1:0]    device_active = '0;

    bus_hub_n_pl #(
        .N_DEVICES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(T), .ERR_RDATA(ERRV)
    ) dut (
        .clk(clk), .rst(rst),
        .host_address(host_address), .host_data_write(host_data_write),
        .host_write_mask(host_write_mask), .host_wen(host_wen), .host_ren(host_ren),
        .host_data_read(host_data_read), .host_ready(host_ready), .host_error(host_error),
        .device_address(device_address), .device_data_write(device_data_write),
        .device_write_mask(device_write_mask), .device_wen(device_wen), .device_ren(device_ren),
        .device_ready(device_ready), .device_data_read(device_data_read),
        .device_active(device_active)
    );

    // Device models: ready after lat[i] strobe cycles, plus a forced-ready override.
    int            lat [N] = '{0, 0, 0};
    int            dcnt [N] = '{0, 0, 0};
    logic [DW-1:0] dev_rdata [N];
    logic [N-1:0]  force_rdy = '0;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst && (device_ren[i] || device_wen[i])) dcnt[i] <= dcnt[i] + 1;
            else                                          dcnt[i] <= 0;
        end
    end

    always_comb begin
        device_ready     = '0;
        device_data_read = '0;
        for (int i = 0; i < N; i++) begin
            device_ready[i] = force_rdy[i] | ((device_ren[i] | device_wen[i]) & (dcnt[i] == lat[i]));
            device_data_read[i*DW +: DW] = dev_rdata[i];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request in the current cycle (cycle 0) and checks the full response.
    task automatic run_txn(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [MW-1:0] m, input logic w, input logic r,
                           input logic [N-1:0] actv);
        int sel, exp_lat, exp_strobes, got, strobes;
        logic exp_err, ok;
        logic [DW-1:0] exp_data, obs_data;
        logic [N-1:0] oh;
        logic obs_err;
        sel = -1;
        for (int i = N - 1; i >= 0; i--) if (actv[i]) sel = i;
        oh = (sel >= 0) ? N'(1 << sel) : '0;
        if (sel < 0) begin
            exp_lat = 2; exp_err = 1'b1; exp_strobes = 0;
        end else begin
            exp_lat = 3 + lat[sel]; exp_err = 1'b0; exp_strobes = lat[sel] + 1;
`ifdef BUS_HUB_TIMEOUT_EN
            if (lat[sel] >= T) begin
                exp_lat = 2 + T; exp_err = 1'b1; exp_strobes = T;
            end
`endif
        end
        if (w)            exp_data = '0;
        else if (exp_err) exp_data = ERRV;
        else              exp_data = dev_rdata[sel];

        host_address = a; host_data_write = d; host_write_mask = m;
        host_wen = w; host_ren = r; device_active = actv;
        step();
        host_wen = 1'b0; host_ren = 1'b0;
        host_address = $urandom; host_data_write = $urandom; host_write_mask = MW'($urandom);
        got = -1; strobes = 0; ok = 1'b1; obs_data = '0; obs_err = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if ((device_ren | device_wen) != '0) begin
                strobes++;
                if (device_ren !== (w ? '0 : oh) || device_wen !== (w ? oh : '0)) ok = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (device_address[i*AW +: AW] !== a || device_data_write[i*DW +: DW] !== d ||
                        device_write_mask[i*MW +: MW] !== m) ok = 1'b0;
                end
            end
            if (host_ready === 1'b1) begin
                got = c; obs_data = host_data_read; obs_err = host_error;
                break;
            end
            step();
        end
        check({tag, "_latency"}, 64'(got), 64'(exp_lat));
        check({tag, "_error"}, 64'(obs_err), 64'(exp_err));
        check({tag, "_rdata"}, 64'(obs_data), 64'(exp_data));
        check({tag, "_strobe_cycles"}, 64'(strobes), 64'(exp_strobes));
        check({tag, "_strobe_target"}, 64'(ok), 64'(1));
        step();
        check({tag, "_no_repeat"}, {62'(0), host_ready, |(device_ren | device_wen)}, 64'(0));
    endtask

    initial begin
        for (int i = 0; i < N; i++) dev_rdata[i] = '0;
        rst = 1'b1;
        step(); step();
        check("reset_host_ready", 64'(host_ready), 64'(0));
        check("reset_host_error", 64'(host_error), 64'(0));
        check("reset_host_rdata", 64'(host_data_read), 64'(0));
        check("reset_dev_strobes", {58'(0), device_ren, device_wen}, 64'(0));
        check("reset_dev_addr", 64'(|device_address), 64'(0));
        check("reset_dev_wdata", 64'(|device_data_write), 64'(0));
        check("reset_dev_mask", 64'(device_write_mask), 64'(0));
        rst = 1'b0;
        step();

        // Registered-ready read from device 1.
        dev_rdata[1] = 32'h1234_5678; lat[1] = 1;
        run_txn("rd_dev1", 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b1, 3'b010);

        dev_rdata[0] = 32'h5555_AAAA; lat[0] = 1;
        run_txn("wr_dev0", 32'h0000_0004, 32'hAABB_CCDD, 4'b0011, 1'b1, 1'b0, 3'b001);

        run_txn("rd_unmapped", 32'hF000_0000, 32'h0, 4'h0, 1'b0, 1'b1, 3'b000);
        run_txn("wr_unmapped", 32'hF000_0004, 32'h1111_2222, 4'hF, 1'b1, 1'b0, 3'b000);

        // Multi-hit: device 0 wins; device 2's spurious ready must be ignored.
        dev_rdata[0] = 32'hCAFE_0000; dev_rdata[2] = 32'hBAD0_0002; lat[0] = 2;
        force_rdy = 3'b100;
        run_txn("rd_multihit", 32'h0000_0020, 32'h0, 4'h0, 1'b0, 1'b1, 3'b101);
        force_rdy = '0;

        run_txn("rdwr_both", 32'h0000_0030, 32'h0BAD_F00D, 4'hA, 1'b1, 1'b1, 3'b110);

`ifdef BUS_HUB_TIMEOUT_EN
        // Timeout, then a stale ready must not create a second response.
        lat[0] = NEVER;
        run_txn("rd_timeout", 32'h0000_0040, 32'h0, 4'h0, 1'b0, 1'b1, 3'b001);
        begin
            int seen;
            seen = 0;
            force_rdy = 3'b001;
            step();
            force_rdy = '0;
            for (int c = 0; c < 10; c++) begin
                if (host_ready !== 1'b0 || device_ren !== '0) seen++;
                step();
            end
            check("stale_ready_ignored", 64'(seen), 64'(0));
        end
`else
        // Without the timeout the hub waits on an unready device indefinitely.
        begin
            int seen;
            seen = 0;
            lat[0] = NEVER;
            host_ren = 1'b1; device_active = 3'b001; host_address = 32'h40;
            step();
            host_ren = 1'b0;
            for (int c = 0; c < 1000; c++) begin
                if (host_ready !== 1'b0) seen++;
                step();
            end
            check("no_timeout_no_ready", 64'(seen), 64'(0));
            check("no_timeout_still_ren", 64'(device_ren), 64'(3'b001));
            rst = 1'b1; step(); rst = 1'b0; step();
        end
`endif

        // Reset during ACCESS aborts the request without a response.
        begin
            int seen;
            seen = 0;
            lat[1] = NEVER;
            host_ren = 1'b1; device_active = 3'b010; host_address = 32'h50;
            step();
            host_ren = 1'b0;
            step(); step();
            check("abort_ren_c3", 64'(device_ren), 64'(3'b010));
            rst = 1'b1;
            step();
            check("abort_ren_c4", 64'(device_ren), 64'(0));
            check("abort_ready_c4", 64'(host_ready), 64'(0));
            rst = 1'b0;
            for (int c = 0; c < 12; c++) begin
                if (host_ready !== 1'b0) seen++;
                step();
            end
            check("abort_no_response", 64'(seen), 64'(0));
        end
        dev_rdata[1] = 32'h0F0F_1234; lat[1] = 1;
        run_txn("rd_after_abort", 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b1, 3'b010);

        for (int t = 0; t < 24; t++) begin
            int opsel;
            logic w, r;
            opsel = int'($urandom_range(0, 2));
            w = (opsel != 0);
            r = (opsel != 1);
            for (int i = 0; i < N; i++) begin
                dev_rdata[i] = $urandom;
`ifdef BUS_HUB_TIMEOUT_EN
                lat[i] = int'($urandom_range(0, 10));
`else
                lat[i] = int'($urandom_range(0, 5));
`endif
            end
            run_txn($sformatf("rand%0d", t), $urandom, $urandom, MW'($urandom_range(0, 15)),
                    w, r, N'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_hub_n_pl.md
Name: bus_hub_n_pl

Overview:
Parametrised N-device successor to the fixed three-device pipelined bus hub. It connects one host (the CPU bus port) to N_DEVICES memory-mapped devices using the existing device_* packed-vector convention. The request is registered before decode, and device selection is priority-based. Unlike the fixed hub, it returns an error response for unmapped addresses and for devices that never signal ready. It sits between cpu_pipelined and the SoC peripherals (memory, parallel port, HUB75 driver, future blocks).

Parameters:
N_DEVICES, 3, number of device ports; slice i occupies bits [(i+1)*W-1 : i*W] of each packed vector.
ADDR_W, 32, address width.
DATA_W, 32, data width; mask width MASK_W = DATA_W/8.
TIMEOUT_CYCLES, 255, max ACCESS cycles waiting for device_ready; must be >= 1.
ERR_RDATA, 32'hDEADBEEF, value returned on an error read.

Ports:
clk  in  1  single clock, all logic posedge
rst  in  1  synchronous, active-high reset
host_address  in  ADDR_W  request address
host_data_write  in  DATA_W  write data
host_write_mask  in  MASK_W  byte enables
host_wen / host_ren  in  1  write / read request; both high is treated as a write
host_data_read  out  DATA_W  registered read data, valid while host_ready=1
host_ready  out  1  one-cycle completion pulse
host_error  out  1  valid with host_ready; 1 = unmapped or timeout
device_address  out  N*ADDR_W  latched address, broadcast to all slices
device_data_write  out  N*DATA_W  latched wdata, broadcast
device_write_mask  out  N*MASK_W  latched mask, broadcast
device_wen / device_ren  out  N  one-hot, selected device only
device_ready  in  N  per-device completion
device_data_read  in  N*DATA_W  per-device read data
device_active  in  N  per-device decode of its device_address slice (combinational in the device)

Behaviour:
- Reset: state=IDLE; all outputs are 0, including latched address/data/mask and the timeout counter. Reset asserted in any state forces device_ren/wen low and host_ready low at that edge. No response is ever issued for an aborted request.
- IDLE: if host_ren|host_wen, latch address, wdata, mask and op (write wins) → DECODE. The host need not hold signals after the latch cycle.
- DECODE (1 cycle): sample device_active.
  - None set → RESP with error.
  - Otherwise latch sel = lowest set index (lowest index wins on multiple hits) → ACCESS, and clear the counter.
- ACCESS: drive device_ren[sel] or device_wen[sel] continuously.
  - On device_ready[sel]=1: capture device_data_read[sel] (reads only; writes capture 0) → RESP.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 with no ready → RESP with error.
  - device_ready and device_data_read of non-selected devices are ignored.
- RESP (1 cycle): host_ready=1; host_error as flagged; host_data_read = captured data, or ERR_RDATA on an error read, or 0 on an error write. device_ren/wen=0 → IDLE.
- A request present in the cycle after RESP is a new transaction. The host must drop ren/wen in that cycle to avoid a repeat.
- Latency, with request seen in IDLE at cycle 0:
  - unmapped: host_ready at cycle 2.
  - device ready in ACCESS cycle k (k >= 2): host_ready at k+1. A registered-ready device gives cycle 4.
  - timeout: host_ready at cycle 2+TIMEOUT_CYCLES.
- Late device_ready after a timeout is ignored. device_ren/wen are already low, so that device is never re-selected for the stale response.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

Optional Feature:
BUS_HUB_TIMEOUT_EN
- Defined: timeout counter and timeout error as above.
- Undefined: no counter is synthesised; ACCESS waits indefinitely for device_ready[sel]; host_error is raised only for unmapped addresses; TIMEOUT_CYCLES is ignored.

Decomposition:
- Package bus_hub_pkg: state enum (IDLE, DECODE, ACCESS, RESP), op enum (OP_READ, OP_WRITE), default ERR_RDATA constant.
- Sub-module bus_prio_sel: parametrised lowest-set-bit encoder; input N-bit vector; outputs one-hot, index ($clog2(N) bits, min 1) and any_set. Used in DECODE.

Test Plan:
- Read 0x0000_0010; only device 1 active; ready registered one cycle after ren with rdata 0x1234_5678 → host_ready at cycle 4, host_data_read=0x1234_5678, host_error=0, device_ren=3'b010 in cycles 2-3 only.
- Write 0xAABB_CCDD with mask 4'b0011; only device 0 active → device_wen=3'b001, all device_write_mask slices=4'b0011, devices 1/2 never see wen, host_ready with host_data_read=0.
- Read with device_active=0 → host_ready at cycle 2, host_error=1, host_data_read=0xDEADBEEF, no device_ren ever asserted.
- device_active=3'b101 → device 0 selected, device 2 ren stays 0.
- With BUS_HUB_TIMEOUT_EN and TIMEOUT_CYCLES=8, device never ready → host_ready+host_error at cycle 10; device ready pulsed at cycle 12 → no second host_ready. Without the macro → no host_ready within 1000 cycles.
- rst pulsed during ACCESS (cycle 3) → device_ren=0 and host_ready=0 from cycle 4; next request completes normally with fresh data.
